// File: rtl/emc_frame_framer_if.sv
// rtl/emc_frame_framer_if.sv - word-stream interface between QDR read-back, framer and EMC output FIFO
interface emc_frame_framer_if;
    logic [63:0] in_data;
    logic        in_valid;
    logic        in_almost_full;
    logic [63:0] out_data;
    logic        out_valid;
    logic        out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_almost_full, out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_almost_full, out_data, out_valid
    );
endinterface

// File: rtl/emc_frame_framer.sv
// rtl/emc_frame_framer.sv - buffers QDR read-back words and wraps each frame in header/trailer words
// Optional per-line marker words: define EMC_LINE_MARKER_EN.
module emc_frame_framer #(
    parameter int LINE_WORDS  = 512,
    parameter int FRAME_LINES = 2048,
    parameter int FIFO_DEPTH  = 16,
    parameter int AF_MARGIN   = 6
) (
    input  logic                emc_clk,
    input  logic                rst,
    emc_frame_framer_if.slave   bus,
    input  logic [4:0]          frame_cal_num_in,
    output logic                frame_done,
    output logic [15:0]         frame_cnt,
    output logic                overflow_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [31:0] HDR_SYNC  = 32'hEB90146F;
    localparam logic [31:0] TRL_SYNC  = 32'h146FEB90;
    localparam logic [AW:0] FULL_CNT  = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] AF_CNT    = (AW+1)'(FIFO_DEPTH - AF_MARGIN);
    localparam logic [15:0] LAST_WORD = 16'(LINE_WORDS - 1);
    localparam logic [15:0] LAST_LINE = 16'(FRAME_LINES - 1);
`ifdef EMC_LINE_MARKER_EN
    localparam logic [31:0] MRK_SYNC  = 32'hEB904C4E;
`endif

    typedef enum logic [1:0] {IDLE, HEADER, DATA, TRAILER} state_t;

    state_t         state_q, state_d;
    logic [63:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW:0]    count_q, count_d;
    logic           af_q, af_d;
    logic           ovf_q, ovf_d;
    logic [4:0]     cal_q, cal_d;
    logic [15:0]    frame_cnt_q, frame_cnt_d;
    logic [15:0]    word_cnt_q, word_cnt_d;
    logic [15:0]    line_cnt_q, line_cnt_d;
    logic [31:0]    sum_q, sum_d;
`ifdef EMC_LINE_MARKER_EN
    logic           mrk_q, mrk_d;
`endif

    logic [63:0]    head;
    logic           full, empty, push, pop;

    always_comb begin
        head          = mem_q[rd_ptr_q];
        full          = (count_q == FULL_CNT);
        empty         = (count_q == '0);
        push          = bus.in_valid && !full;
        pop           = 1'b0;
        state_d       = state_q;
        cal_d         = cal_q;
        frame_cnt_d   = frame_cnt_q;
        word_cnt_d    = word_cnt_q;
        line_cnt_d    = line_cnt_q;
        sum_d         = sum_q;
`ifdef EMC_LINE_MARKER_EN
        mrk_d         = mrk_q;
`endif
        bus.out_valid = 1'b0;
        bus.out_data  = '0;
        frame_done    = 1'b0;
        // The full test uses the pre-read count, so a write racing a pop while full is still dropped.
        ovf_d         = ovf_q | (bus.in_valid && full);
        af_d          = (count_q >= AF_CNT);

        case (state_q)
            IDLE: begin
                if (!empty) begin
                    cal_d      = frame_cal_num_in;
                    sum_d      = '0;
                    word_cnt_d = '0;
                    line_cnt_d = '0;
`ifdef EMC_LINE_MARKER_EN
                    mrk_d      = 1'b1;
`endif
                    state_d    = HEADER;
                end
            end
            HEADER: begin
                bus.out_valid = 1'b1;
                bus.out_data  = {HDR_SYNC, 11'h0, cal_q, frame_cnt_q};
                if (bus.out_ready) state_d = DATA;
            end
            DATA: begin
`ifdef EMC_LINE_MARKER_EN
                if (mrk_q) begin
                    bus.out_valid = 1'b1;
                    bus.out_data  = {MRK_SYNC, 16'h0, line_cnt_q};
                    if (bus.out_ready) mrk_d = 1'b0;
                end else
`endif
                if (!empty) begin
                    bus.out_valid = 1'b1;
                    bus.out_data  = head;
                    if (bus.out_ready) begin
                        pop   = 1'b1;
                        sum_d = sum_q + head[63:32] + head[31:0];
                        if (word_cnt_q == LAST_WORD) begin
                            word_cnt_d = '0;
                            line_cnt_d = line_cnt_q + 16'd1;
`ifdef EMC_LINE_MARKER_EN
                            mrk_d      = 1'b1;
`endif
                            if (line_cnt_q == LAST_LINE) state_d = TRAILER;
                        end else begin
                            word_cnt_d = word_cnt_q + 16'd1;
                        end
                    end
                end
            end
            TRAILER: begin
                bus.out_valid = 1'b1;
                bus.out_data  = {TRL_SYNC, sum_q};
                if (bus.out_ready) begin
                    frame_done  = 1'b1;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
    end

    always_ff @(posedge emc_clk) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            af_q        <= 1'b0;
            ovf_q       <= 1'b0;
            cal_q       <= '0;
            frame_cnt_q <= '0;
            word_cnt_q  <= '0;
            line_cnt_q  <= '0;
            sum_q       <= '0;
`ifdef EMC_LINE_MARKER_EN
            mrk_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            af_q        <= af_d;
            ovf_q       <= ovf_d;
            cal_q       <= cal_d;
            frame_cnt_q <= frame_cnt_d;
            word_cnt_q  <= word_cnt_d;
            line_cnt_q  <= line_cnt_d;
            sum_q       <= sum_d;
`ifdef EMC_LINE_MARKER_EN
            mrk_q       <= mrk_d;
`endif
        end
    end

    always_ff @(posedge emc_clk) begin
        if (push) mem_q[wr_ptr_q] <= bus.in_data;
    end

    assign bus.in_almost_full = af_q;
    assign frame_cnt          = frame_cnt_q;
    assign overflow_err       = ovf_q;

endmodule

// File: tb/tb_emc_frame_framer.sv
// tb/tb_emc_frame_framer.sv - scoreboard bench for emc_frame_framer (LINE_WORDS=4, FRAME_LINES=2)
module tb_emc_frame_framer;
    localparam int LW = 4;
    localparam int FL = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  cal;
    logic        frame_done;
    logic [15:0] frame_cnt;
    logic        overflow_err;

    emc_frame_framer_if bus ();

    emc_frame_framer #(
        .LINE_WORDS(LW), .FRAME_LINES(FL), .FIFO_DEPTH(16), .AF_MARGIN(6)
    ) dut (
        .emc_clk          (clk),
        .rst              (rst),
        .bus              (bus),
        .frame_cal_num_in (cal),
        .frame_done       (frame_done),
        .frame_cnt        (frame_cnt),
        .overflow_err     (overflow_err)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          failed = 0;
    logic [63:0] exp_q [$];
    int          m_idx = 0;
    logic [31:0] m_sum = '0;
    logic [15:0] m_fcnt = '0;
    logic [4:0]  m_cal = '0;
    int          cyc = 0;
    int          done_cnt = 0;
    bit          lat_arm = 0;
    int          lat_cyc = 0;
    bit          prev_stall = 0;
    logic [63:0] prev_data = '0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 0;
        end else begin
            if (lat_arm && bus.out_valid) begin
                lat_cyc = cyc;
                lat_arm = 0;
            end
            if (prev_stall) begin
                check("hold_valid", 64'(bus.out_valid), 64'd1);
                check("hold_data", bus.out_data, prev_data);
            end
            if (frame_done) done_cnt++;
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    failed++;
                    $display("FAIL unexpected_out: got %h expected no word", bus.out_data);
                end else begin
                    check("out_word", bus.out_data, exp_q.pop_front());
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
        end
    end

    task automatic push_marker(input int line);
`ifdef EMC_LINE_MARKER_EN
        exp_q.push_back({32'hEB904C4E, 16'h0, 16'(line)});
`endif
    endtask

    // Reference frame builder for the model-driven scenarios.
    task automatic issue(input logic [63:0] w);
        if (m_idx == 0) begin
            exp_q.push_back({32'hEB90146F, 11'h0, m_cal, m_fcnt});
            m_sum = '0;
        end
        if (m_idx % LW == 0) push_marker(m_idx / LW);
        exp_q.push_back(w);
        m_sum = m_sum + w[63:32] + w[31:0];
        m_idx++;
        if (m_idx == LW * FL) begin
            exp_q.push_back({32'h146FEB90, m_sum});
            m_idx  = 0;
            m_fcnt = m_fcnt + 16'd1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [63:0] w);
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic send(input logic [63:0] w);
        issue(w);
        drive(w);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_idx  = 0;
        m_fcnt = '0;
        m_sum  = '0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        tests++;
        if (exp_q.size() != 0) begin
            failed++;
            $display("FAIL %s_drain: %0d words still expected, required 0", name, exp_q.size());
            exp_q.delete();
        end
        tick();
        tick();
        check({name, "_idle_valid"}, 64'(bus.out_valid), 64'd0);
    endtask

    function automatic logic [63:0] wgen(input int i);
        return {32'hA5A50000 + 32'(i), 32'h00001000 + 32'(i * 3)};
    endfunction

    initial begin
        int sent;
        int n;
        int lat_start;
        int done0;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        cal           = '0;
        tick();
        tick();
        rst = 1'b0;

        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_data", bus.out_data, 64'd0);
        check("rst_almost_full", 64'(bus.in_almost_full), 64'd0);
        check("rst_frame_done", 64'(frame_done), 64'd0);
        check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
        check("rst_overflow", 64'(overflow_err), 64'd0);

        // Single frame, words 1..8, cal 5
        cal = 5'd5;
        exp_q.push_back(64'hEB90146F_00050000);
        push_marker(0);
        for (int i = 1; i <= 4; i++) exp_q.push_back(64'(i));
        push_marker(1);
        for (int i = 5; i <= 8; i++) exp_q.push_back(64'(i));
        exp_q.push_back(64'h146FEB90_00000024);
        lat_start = cyc;
        lat_arm   = 1;
        for (int i = 1; i <= 8; i++) drive(64'(i));
        drain("s1");
        check("s1_latency", 64'(lat_cyc - lat_start), 64'd2);
        check("s1_done_pulses", 64'(done_cnt), 64'd1);
        check("s1_frame_cnt", 64'(frame_cnt), 64'd1);

        // Backpressure: consumer stalled, producer honours in_almost_full
        m_idx = 0; m_fcnt = 16'd1; m_cal = 5'd2; cal = 5'd2;
        bus.out_ready = 1'b0;
        sent = 0;
        while (sent < 16 && !bus.in_almost_full) begin
            send(wgen(sent));
            sent++;
        end
        check("s2_words_before_af", 64'(sent), 64'd11);
        check("s2_almost_full", 64'(bus.in_almost_full), 64'd1);
        check("s2_no_overflow", 64'(overflow_err), 64'd0);
        bus.out_ready = 1'b1;
        n = 0;
        while (sent < 16 && n < 200) begin
            if (!bus.in_almost_full) begin
                send(wgen(sent));
                sent++;
            end else begin
                tick();
            end
            n++;
        end
        check("s2_all_sent", 64'(sent), 64'd16);
        drain("s2");
        check("s2_frame_cnt", 64'(frame_cnt), 64'd3);
        check("s2_no_overflow_end", 64'(overflow_err), 64'd0);

        // Back-to-back frames, cal 3 then 7
        do_reset();
        done0 = done_cnt;
        cal = 5'd3;
        exp_q.push_back(64'hEB90146F_00030000);
        push_marker(0);
        for (int i = 1; i <= 4; i++) exp_q.push_back(64'(i));
        push_marker(1);
        for (int i = 5; i <= 8; i++) exp_q.push_back(64'(i));
        exp_q.push_back(64'h146FEB90_00000024);
        exp_q.push_back(64'hEB90146F_00070001);
        push_marker(0);
        for (int i = 9; i <= 12; i++) exp_q.push_back(64'(i));
        push_marker(1);
        for (int i = 13; i <= 16; i++) exp_q.push_back(64'(i));
        exp_q.push_back(64'h146FEB90_00000064);
        for (int i = 1; i <= 8; i++) drive(64'(i));
        cal = 5'd7;
        for (int i = 9; i <= 16; i++) drive(64'(i));
        drain("s3");
        check("s3_frame_cnt", 64'(frame_cnt), 64'd2);
        check("s3_done_pulses", 64'(done_cnt - done0), 64'd2);

        // Reset mid-frame after three data words
        m_idx = 0; m_fcnt = 16'd2; m_cal = 5'd4; cal = 5'd4;
        for (int i = 0; i < 3; i++) send(wgen(40 + i));
        for (int i = 0; i < 6; i++) tick();
        check("s4_partial_emitted", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        do_reset();
        check("s4_rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("s4_rst_frame_cnt", 64'(frame_cnt), 64'd0);
        check("s4_rst_overflow", 64'(overflow_err), 64'd0);
        m_cal = 5'd6; cal = 5'd6;
        for (int i = 0; i < 8; i++) send(wgen(60 + i));
        drain("s4");
        check("s4_frame_cnt", 64'(frame_cnt), 64'd1);

        // Overflow: 17 words into a stalled 16-deep buffer
        do_reset();
        bus.out_ready = 1'b0;
        m_cal = 5'd1; cal = 5'd1;
        for (int i = 0; i < 16; i++) send(wgen(80 + i));
        drive(64'hDEADBEEF_0BADF00D);
        tick();
        check("s5_overflow_set", 64'(overflow_err), 64'd1);
        bus.out_ready = 1'b1;
        drain("s5");
        check("s5_overflow_sticky", 64'(overflow_err), 64'd1);
        check("s5_frame_cnt", 64'(frame_cnt), 64'd2);
        do_reset();
        check("s5_overflow_cleared", 64'(overflow_err), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
